// File: rtl/led_pattern_ctrl.sv
// LED pattern controller: three debounced pushbuttons select the pattern mode,
// the step speed and a pause; the LED register steps once per period.
module led_pattern_ctrl #(
  parameter int LED_W       = 4,
  parameter int STEP_CYCLES = 25_000_000,
  parameter int DEB_CYCLES  = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       key,
  output logic [LED_W-1:0] led,
  output logic [2:0]       mode,
  output logic [1:0]       speed,
  output logic             paused
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHL    = 3'd1,
    SHR    = 3'd2,
    BLINK  = 3'd3,
    BOUNCE = 3'd4
  } mode_t;

  localparam int DW = $clog2(DEB_CYCLES);
  localparam int SW = $clog2(STEP_CYCLES);
  localparam logic [DW-1:0]    DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [DW-1:0]    DEB_ONE  = DW'(1);
  localparam logic [SW-1:0]    STEP_ONE = SW'(1);
  localparam logic [31:0]      STEP_P   = 32'(STEP_CYCLES);
  localparam logic [LED_W-1:0] PAT_LO   = LED_W'(1);
  localparam logic [LED_W-1:0] PAT_HI   = {1'b1, {(LED_W-1){1'b0}}};

  logic [2:0]    key_s1, key_s2, key_deb, press;
  logic [DW-1:0] deb_cnt [3];

  // Keys are active-low, so reset parks every stage at 1 (released).
  // press[i] is registered in the same edge the debounced state falls.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_s1  <= 3'b111;
      key_s2  <= 3'b111;
      key_deb <= 3'b111;
      press   <= 3'b000;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      key_s1 <= key;
      key_s2 <= key_s1;
      press  <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        if (key_s2[i] == key_deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          key_deb[i] <= key_s2[i];
          deb_cnt[i] <= '0;
          press[i]   <= key_deb[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_ONE;
        end
      end
    end
  end

  mode_t            mode_q, mode_next;
  logic [SW-1:0]    step_cnt;
  logic             dir_up, dir_stepped, tick;
  logic [31:0]      period_m1;
  logic [LED_W-1:0] led_stepped, init_pat;

  assign mode = mode_q;

  always_comb begin
    period_m1 = (STEP_P >> speed) - 32'd1;
    tick      = (mode_q != IDLE) && !paused && (32'(step_cnt) == period_m1);
  end

  always_comb begin
    mode_next = IDLE;
    init_pat  = PAT_LO;
    case (mode_q)
      IDLE:    mode_next = SHL;
      SHL:     begin mode_next = SHR; init_pat = PAT_HI; end
      SHR:     begin mode_next = BLINK; init_pat = '1; end
      BLINK:   mode_next = BOUNCE;
      default: mode_next = IDLE;
    endcase
  end

  // Bounce turns around at the ends so each end is lit for a single step.
  always_comb begin
    led_stepped = led;
    dir_stepped = dir_up;
    case (mode_q)
      SHL:   led_stepped = {led[LED_W-2:0], led[LED_W-1]};
      SHR:   led_stepped = {led[0], led[LED_W-1:1]};
      BLINK: led_stepped = ~led;
      BOUNCE: begin
        if (dir_up) begin
          if (led[LED_W-1]) begin
            dir_stepped = 1'b0;
            led_stepped = led >> 1;
          end else begin
            led_stepped = led << 1;
          end
        end else begin
          if (led[0]) begin
            dir_stepped = 1'b1;
            led_stepped = led << 1;
          end else begin
            led_stepped = led >> 1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= IDLE;
      led      <= PAT_LO;
      speed    <= 2'd0;
      paused   <= 1'b0;
      dir_up   <= 1'b1;
      step_cnt <= '0;
    end else begin
      if (press[2]) paused <= ~paused;
      if (press[1]) speed <= (speed == 2'd2) ? 2'd0 : speed + 2'd1;

      // A mode load overrides a same-cycle tick.
      if (press[0]) begin
        mode_q <= mode_next;
        led    <= init_pat;
        dir_up <= 1'b1;
      end else if (tick) begin
        led    <= led_stepped;
        dir_up <= dir_stepped;
      end

      if (press[0] || press[1] || mode_q == IDLE || tick) step_cnt <= '0;
      else if (!paused) step_cnt <= step_cnt + STEP_ONE;
    end
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl with LED_W=4, STEP_CYCLES=8, DEB_CYCLES=4.
// State is compared as {led, mode, speed, paused} against a scoreboard queue.
module tb_led_pattern_ctrl;
  localparam int W = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] key;
  logic [3:0] led;
  logic [2:0] mode;
  logic [1:0] speed;
  logic       paused;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp;
  logic [W-1:0] dut_state;

  assign dut_state = {led, mode, speed, paused};

  led_pattern_ctrl #(.LED_W(4), .STEP_CYCLES(8), .DEB_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .key(key), .led(led),
    .mode(mode), .speed(speed), .paused(paused)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] st(logic [3:0] l, logic [2:0] m, logic [1:0] s, logic p);
    return {l, m, s, p};
  endfunction

  task automatic check_eq(string tag, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic pop_check(string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, 32'(dut_state), 32'(e));
      last_exp = e;
    end
  endtask

  // Waits one step period: led must hold until the last edge, then change.
  task automatic step(int period, string tag);
    repeat (period - 1) @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_hold"}, 32'(led), 32'(last_exp[9:6]));
    @(posedge clk);
    @(negedge clk);
    pop_check(tag);
  endtask

  task automatic exp_step(logic [3:0] l, int period, string tag);
    exp_q.push_back({l, last_exp[5:0]});
    step(period, tag);
  endtask

  task automatic idle_check(int cycles, string tag);
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    check_eq(tag, 32'(dut_state), 32'(last_exp));
  endtask

  // Drives keys low mid-cycle; the effect lands on the 7th edge after that.
  task automatic press_key(logic [2:0] mask, int hold, string tag);
    key = key & ~mask;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_early"}, 32'(dut_state[5:0]), 32'(last_exp[5:0]));
    @(posedge clk);
    @(negedge clk);
    pop_check(tag);
    repeat (hold - 7) @(posedge clk);
    if (hold > 7) @(negedge clk);
    key = key | mask;
  endtask

  initial begin
    int gl;
    rst = 1'b1;
    key = 3'b111;
    last_exp = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    exp_q.push_back(st(4'b0001, 3'd0, 2'd0, 1'b0));
    pop_check("reset");
    rst = 1'b0;
    idle_check(50, "idle_static");

    gl = $urandom_range(1, 3);
    key[0] = 1'b0;
    repeat (gl) @(posedge clk);
    @(negedge clk);
    key[0] = 1'b1;
    idle_check(20, "glitch");

    exp_q.push_back(st(4'b0001, 3'd1, 2'd0, 1'b0));
    press_key(3'b001, 30, "long_hold");
    repeat (20) @(posedge clk);
    @(negedge clk);
    check_eq("hold_once", 32'(mode), 32'd1);

    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(st(4'b0001, 3'd0, 2'd0, 1'b0));
    pop_check("rst_mid_step");

    key[0] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    key[0] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle_check(20, "rst_mid_debounce");

    exp_q.push_back(st(4'b0001, 3'd1, 2'd0, 1'b0));
    press_key(3'b001, 7, "to_shl");
    exp_step(4'b0010, 8, "shl1");
    exp_step(4'b0100, 8, "shl2");
    exp_step(4'b1000, 8, "shl3");
    exp_step(4'b0001, 8, "shl4");

    exp_q.push_back(st(4'b1000, 3'd2, 2'd0, 1'b0));
    press_key(3'b001, 7, "to_shr");
    exp_step(4'b0100, 8, "shr1");
    exp_step(4'b0010, 8, "shr2");

    exp_q.push_back(st(4'b1111, 3'd3, 2'd0, 1'b0));
    press_key(3'b001, 7, "to_blink");
    exp_step(4'b0000, 8, "blink1");
    exp_step(4'b1111, 8, "blink2");

    exp_q.push_back(st(4'b1111, 3'd3, 2'd0, 1'b1));
    press_key(3'b100, 7, "pause");
    idle_check(20, "paused_hold");
    exp_q.push_back(st(4'b0001, 3'd4, 2'd0, 1'b1));
    press_key(3'b001, 7, "mode_while_paused");
    idle_check(20, "paused_bounce_hold");
    exp_q.push_back(st(4'b0001, 3'd4, 2'd0, 1'b0));
    press_key(3'b100, 7, "resume");

    exp_step(4'b0010, 8, "bounce1");
    exp_step(4'b0100, 8, "bounce2");
    exp_step(4'b1000, 8, "bounce3");
    exp_step(4'b0100, 8, "bounce4");
    exp_step(4'b0010, 8, "bounce5");
    exp_step(4'b0001, 8, "bounce6");
    exp_step(4'b0010, 8, "bounce7");

    exp_q.push_back(st(4'b0010, 3'd4, 2'd1, 1'b0));
    press_key(3'b010, 7, "speed1");
    exp_step(4'b0100, 4, "sp1_step1");
    exp_step(4'b1000, 4, "sp1_step2");
    exp_step(4'b0100, 4, "sp1_step3");

    exp_q.push_back(st(4'b0010, 3'd4, 2'd2, 1'b0));
    press_key(3'b010, 7, "speed2");
    exp_step(4'b0001, 2, "sp2_step1");
    exp_step(4'b0010, 2, "sp2_step2");
    exp_step(4'b0100, 2, "sp2_step3");
    exp_step(4'b1000, 2, "sp2_step4");

    exp_q.push_back(st(4'b0001, 3'd0, 2'd0, 1'b0));
    press_key(3'b011, 7, "mode_speed_same_edge");
    idle_check(30, "idle_after_wrap");

    rst = 1'b1;
    key[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(st(4'b0001, 3'd1, 2'd0, 1'b0));
    press_key(3'b001, 7, "held_thru_reset");
    repeat (20) @(posedge clk);
    @(negedge clk);
    check_eq("held_thru_reset_once", 32'(mode), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
